// File: rtl/systolic_conv_sequencer.sv
// Streams an IMG_DIM x IMG_DIM feature map into a stacked systolic array as overlapping
// row bands, and tags each valid array result with its output-buffer address.
module systolic_conv_sequencer #(
    parameter int          WIDTH          = 8,
    parameter int          IMG_DIM        = 8,
    parameter int          LANES          = 5,
    parameter int          KERNEL         = 3,
    parameter int          PIPE_LAT       = 4,
    parameter int          MEM_ADDR_WIDTH = 4,
    parameter int          COL_ADDR_WIDTH = 3,
    parameter int          OUT_ADDR_WIDTH = 5,
    parameter logic [31:0] CTRL_RUN       = 32'h1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MEM_ADDR_WIDTH-1:0]   filter_sel,
    input  logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic [COL_ADDR_WIDTH-1:0]   in_raddr,
    input  logic [IMG_DIM*WIDTH-1:0]    in_rdata,
    output logic                        sa_ce,
    output logic [31:0]                 sa_ctrl,
    output logic [MEM_ADDR_WIDTH-1:0]   sa_mem_addr,
    output logic [LANES*WIDTH-1:0]      sa_x_ins,
    input  logic [WIDTH-1:0]            sa_y_out,
    output logic                        out_valid,
    output logic [OUT_ADDR_WIDTH-1:0]   out_addr,
    output logic [WIDTH-1:0]            out_data
);

    localparam int NUM_BANDS = IMG_DIM - LANES + 1;
    localparam int OUT_COLS  = IMG_DIM - KERNEL + 1;
    localparam int FLUSH_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t                      state_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        ce_reg;
    logic                        out_valid_reg;
    logic                        col_held_reg;
    logic [COL_ADDR_WIDTH-1:0]   in_raddr_reg;
    logic [COL_ADDR_WIDTH-1:0]   col_reg;
    logic [COL_ADDR_WIDTH-1:0]   band_reg;
    logic [FLUSH_W-1:0]          flush_reg;
    logic [31:0]                 ctrl_reg;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [LANES*WIDTH-1:0]      x_ins_reg;
    logic [OUT_ADDR_WIDTH-1:0]   out_addr_reg;
    logic [WIDTH-1:0]            out_data_reg;
    logic [IMG_DIM*WIDTH-1:0]    col_hold_reg;
    logic                        tag_valid_reg [PIPE_LAT];
    logic [OUT_ADDR_WIDTH-1:0]   tag_addr_reg  [PIPE_LAT];

    logic                        active;
    logic                        last_col;
    logic                        last_band;
    logic                        flush_last;
    logic                        tag_in_valid;
    logic [OUT_ADDR_WIDTH-1:0]   tag_in_addr;
    logic [COL_ADDR_WIDTH-1:0]   raddr_next;
    logic [IMG_DIM*WIDTH-1:0]    col_data;
    logic [LANES*WIDTH-1:0]      x_ins_next;

    assign active       = busy_reg & ~hold;
    // While stalled the buffer keeps reading, so the fetched column is replayed from the capture register.
    assign col_data     = col_held_reg ? col_hold_reg : in_rdata;
    assign last_col     = (int'(col_reg) == IMG_DIM - 1);
    assign last_band    = (int'(band_reg) == NUM_BANDS - 1);
    assign flush_last   = (int'(flush_reg) == PIPE_LAT - 1);
    assign raddr_next   = (int'(in_raddr_reg) == IMG_DIM - 1) ? '0 : in_raddr_reg + 1'b1;
    assign tag_in_valid = (state_reg == S_STREAM) && (int'(col_reg) >= KERNEL - 1);
    assign tag_in_addr  = OUT_ADDR_WIDTH'(int'(band_reg) * OUT_COLS + int'(col_reg) - (KERNEL - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign x_ins_next[gi*WIDTH +: WIDTH] = col_data[(int'(band_reg) + gi)*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ce_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            col_held_reg  <= 1'b0;
            in_raddr_reg  <= '0;
            col_reg       <= '0;
            band_reg      <= '0;
            flush_reg     <= '0;
            ctrl_reg      <= '0;
            mem_addr_reg  <= '0;
            x_ins_reg     <= '0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
            col_hold_reg  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_valid_reg[i] <= 1'b0;
                tag_addr_reg[i]  <= '0;
            end
        end else begin
            done_reg <= 1'b0;

            if (busy_reg && hold) begin
                out_valid_reg <= 1'b0;
                if (!col_held_reg) begin
                    col_hold_reg <= in_rdata;
                    col_held_reg <= 1'b1;
                end
            end

            if (!active) begin
                out_valid_reg <= 1'b0;
            end else begin
                col_held_reg     <= 1'b0;
                tag_valid_reg[0] <= tag_in_valid;
                tag_addr_reg[0]  <= tag_in_addr;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    tag_valid_reg[i] <= tag_valid_reg[i-1];
                    tag_addr_reg[i]  <= tag_addr_reg[i-1];
                end
                out_valid_reg <= tag_valid_reg[PIPE_LAT-1];
                if (tag_valid_reg[PIPE_LAT-1]) begin
                    out_addr_reg <= tag_addr_reg[PIPE_LAT-1];
                    out_data_reg <= sa_y_out;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    busy_reg     <= 1'b0;
                    ce_reg       <= 1'b0;
                    ctrl_reg     <= '0;
                    in_raddr_reg <= '0;
                    col_held_reg <= 1'b0;
                    if (start && !busy_reg) begin
                        busy_reg     <= 1'b1;
                        ce_reg       <= 1'b1;
                        mem_addr_reg <= filter_sel;
                        col_reg      <= '0;
                        band_reg     <= '0;
                        flush_reg    <= '0;
                        state_reg    <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (active) begin
                        in_raddr_reg <= raddr_next;
                        state_reg    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (active) begin
                        x_ins_reg    <= x_ins_next;
                        ctrl_reg     <= CTRL_RUN;
                        in_raddr_reg <= raddr_next;
                        if (last_col) begin
                            col_reg  <= '0;
                            band_reg <= band_reg + 1'b1;
                            if (last_band) begin
                                flush_reg <= '0;
                                state_reg <= S_FLUSH;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (active) begin
                        x_ins_reg <= '0;
                        ctrl_reg  <= '0;
                        flush_reg <= flush_reg + 1'b1;
                        if (flush_last) begin
                            ce_reg    <= 1'b0;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (active) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign in_raddr    = in_raddr_reg;
    assign sa_ce       = ce_reg & ~hold;
    assign sa_ctrl     = ctrl_reg;
    assign sa_mem_addr = mem_addr_reg;
    assign sa_x_ins    = x_ins_reg;
    assign out_valid   = out_valid_reg;
    assign out_addr    = out_addr_reg;
    assign out_data    = out_data_reg;

endmodule

// File: tb/tb_systolic_conv_sequencer.sv
// Randomized bench for systolic_conv_sequencer: per-cycle comparison against a schedule
// derived from active-cycle counting, plus directed checks on the fixed 8x8 map.
module tb_systolic_conv_sequencer;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int L  = 5;
    localparam int K  = 3;
    localparam int PL = 4;
    localparam int NB = N - L + 1;
    localparam int OC = N - K + 1;
    localparam int NC = 96;
    localparam int J_DONE = 2 + NB*N + PL;

    logic          clk = 1'b0;
    logic          rst, start, hold;
    logic [3:0]    filter_sel;
    logic          busy, done;
    logic [2:0]    in_raddr;
    logic [N*W-1:0] in_rdata;
    logic          sa_ce;
    logic [31:0]   sa_ctrl;
    logic [3:0]    sa_mem_addr;
    logic [L*W-1:0] sa_x_ins;
    logic [W-1:0]  sa_y_out;
    logic          out_valid;
    logic [4:0]    out_addr;
    logic [W-1:0]  out_data;

    systolic_conv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .filter_sel(filter_sel), .hold(hold),
        .busy(busy), .done(done), .in_raddr(in_raddr), .in_rdata(in_rdata),
        .sa_ce(sa_ce), .sa_ctrl(sa_ctrl), .sa_mem_addr(sa_mem_addr), .sa_x_ins(sa_x_ins),
        .sa_y_out(sa_y_out), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]   img [N][N];
    bit             hv [NC];
    logic [W-1:0]   yv [NC];
    logic [L*W-1:0] ex_x [NC];
    logic [31:0]    ex_ctrl [NC];
    bit             ex_ce [NC], ex_ov [NC], ex_done [NC], ex_busy [NC];
    logic [4:0]     ex_oa [NC];
    logic [W-1:0]   ex_od [NC];
    logic [3:0]     ex_ma [NC];

    int             ov_cnt, first_ov, done_cnt, done_cyc, first_run, next_addr;
    logic [W-1:0]   first_od;
    logic [L*W-1:0] x_c2, x_c10;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] col_word(input int c);
        logic [N*W-1:0] w;
        for (int r = 0; r < N; r++) w[r*W +: W] = img[r][c];
        return w;
    endfunction

    function automatic logic [L*W-1:0] band_slice(input int b, input int c);
        logic [L*W-1:0] x;
        for (int k = 0; k < L; k++) x[k*W +: W] = img[b+k][c];
        return x;
    endfunction

    // Active edge j (j=0 is the accepting edge) happens at edge E[j]; everything follows from j:
    // presentation n at j=n+2, its result at j=n+2+PL, done at j=2+NB*N+PL.
    task automatic build_model(input int rst_k, input logic [3:0] fsel0);
        int E [J_DONE+1];
        int act [NC];
        int j, jj, n;
        logic [L*W-1:0] cur_x;
        logic [31:0]    cur_ctrl;
        logic [4:0]     cur_oa;
        logic [W-1:0]   cur_od;
        bit             ov;
        for (int i = 0; i <= J_DONE; i++) E[i] = NC + 100;
        for (int c = 0; c < NC; c++) act[c] = -1;
        E[0] = 0;
        j = 1;
        for (int k = 1; k < NC && j <= J_DONE; k++) begin
            if (!hv[k]) begin
                E[j] = k;
                j++;
            end
        end
        for (int i = 0; i <= J_DONE; i++) if (E[i] < NC) act[E[i]] = i;
        cur_x = '0; cur_ctrl = '0; cur_oa = '0; cur_od = '0;
        for (int c = 0; c < NC; c++) begin
            jj = act[c];
            ov = 1'b0;
            if (jj >= 2 && jj < 2 + NB*N) begin
                cur_x    = band_slice((jj-2) / N, (jj-2) % N);
                cur_ctrl = 32'h1;
            end else if (jj == 2 + NB*N) begin
                cur_x    = '0;
                cur_ctrl = '0;
            end
            if (jj >= 2 + PL && jj < 2 + NB*N + PL) begin
                n = jj - 2 - PL;
                if (n % N >= K - 1) begin
                    ov     = 1'b1;
                    cur_oa = 5'((n / N) * OC + (n % N) - (K - 1));
                    cur_od = yv[c];
                end
            end
            ex_x[c]    = cur_x;
            ex_ctrl[c] = cur_ctrl;
            ex_oa[c]   = cur_oa;
            ex_od[c]   = cur_od;
            ex_ov[c]   = ov;
            ex_ce[c]   = (c < E[J_DONE-1]) && !((c + 1 < NC) && hv[c+1]);
            ex_done[c] = (c == E[J_DONE]);
            ex_busy[c] = (c <= E[J_DONE]);
            ex_ma[c]   = fsel0;
            if (rst_k >= 0 && c >= rst_k) begin
                ex_x[c] = '0; ex_ctrl[c] = '0; ex_oa[c] = '0; ex_od[c] = '0; ex_ov[c] = 1'b0;
                ex_ce[c] = 1'b0; ex_done[c] = 1'b0; ex_busy[c] = 1'b0; ex_ma[c] = '0;
            end
        end
    endtask

    task automatic run_scenario(input string name, input int hold_lo, input int hold_hi,
                                input int rst_k, input int k2nd, input logic [3:0] fsel0,
                                input logic [3:0] fsel1, input bit rand_hold);
        logic [2:0] a;
        int c;
        for (int k = 0; k < NC; k++) begin
            hv[k] = (k >= hold_lo && k <= hold_hi) ||
                    (rand_hold && k >= 1 && k < 40 && $urandom_range(0, 5) == 0);
            yv[k] = W'($urandom);
        end
        build_model(rst_k, fsel0);
        ov_cnt = 0; first_ov = -1; done_cnt = 0; done_cyc = -1; first_run = -1;
        first_od = '0; x_c2 = '0; x_c10 = '0; next_addr = 0;

        rst = 1'b1; start = 1'b0; hold = 1'b0; filter_sel = '0; sa_y_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({name, " rst busy"}, busy, 0);
        check({name, " rst done"}, done, 0);
        check({name, " rst raddr"}, in_raddr, 0);
        check({name, " rst ce"}, sa_ce, 0);
        check({name, " rst ctrl"}, sa_ctrl, 0);
        check({name, " rst memaddr"}, sa_mem_addr, 0);
        check({name, " rst xins"}, sa_x_ins, 0);
        check({name, " rst oval"}, out_valid, 0);
        check({name, " rst oaddr"}, out_addr, 0);
        check({name, " rst odata"}, out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_rdata = col_word(0);

        for (int k = 0; k < NC; k++) begin
            start      = (k == 0) || (k == k2nd);
            hold       = hv[k];
            rst        = (k == rst_k);
            filter_sel = (k == 0) ? fsel0 : fsel1;
            sa_y_out   = yv[k];
            @(negedge clk);
            if (k >= 1) begin
                c = k - 1;
                check($sformatf("%s busy@%0d", name, c), busy, ex_busy[c]);
                check($sformatf("%s done@%0d", name, c), done, ex_done[c]);
                check($sformatf("%s ce@%0d", name, c), sa_ce, ex_ce[c]);
                check($sformatf("%s ctrl@%0d", name, c), sa_ctrl, ex_ctrl[c]);
                check($sformatf("%s memaddr@%0d", name, c), sa_mem_addr, ex_ma[c]);
                check($sformatf("%s xins@%0d", name, c), sa_x_ins, ex_x[c]);
                check($sformatf("%s oval@%0d", name, c), out_valid, ex_ov[c]);
                check($sformatf("%s oaddr@%0d", name, c), out_addr, ex_oa[c]);
                check($sformatf("%s odata@%0d", name, c), out_data, ex_od[c]);
                if (out_valid) begin
                    $display("%s cycle %0d out addr=%0d data=%0h", name, c, out_addr, out_data);
                    check($sformatf("%s order@%0d", name, c), out_addr, next_addr);
                    next_addr++;
                    ov_cnt++;
                    if (first_ov < 0) begin
                        first_ov = c;
                        first_od = out_data;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = c;
                end
                if (sa_ctrl == 32'h1 && first_run < 0) first_run = c;
                if (c == 2)  x_c2  = sa_x_ins;
                if (c == 10) x_c10 = sa_x_ins;
            end
            a = in_raddr;
            @(posedge clk);
            #1;
            in_rdata = col_word(int'(a));
        end
        start = 1'b0;
        hold  = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic fixed_image();
        logic [W-1:0] row0 [N];
        logic [W-1:0] col0 [N];
        row0 = '{8'd0, 8'd1, 8'd4, 8'd2, 8'd2, 8'd0, 8'd0, 8'd3};
        col0 = '{8'd0, 8'd7, 8'd4, 8'd2, 8'd11, 8'd0, 8'd4, 8'd3};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = W'($urandom);
        for (int c = 0; c < N; c++) img[0][c] = row0[c];
        for (int r = 0; r < N; r++) img[r][0] = col0[r];
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; filter_sel = '0;
        sa_y_out = '0; in_rdata = '0;
        fixed_image();

        run_scenario("base", -1, -1, -1, -1, 4'd0, 4'd0, 1'b0);
        check("base xins@2", x_c2, 40'h0B_02_04_07_00);
        check("base xins@10", x_c10, 40'h00_0B_02_04_07);
        check("base first_run", first_run, 2);
        check("base done_cycle", done_cyc, 38);
        check("base out_count", ov_cnt, 24);
        check("base first_out", first_ov, 8);
        check("base first_data", first_od, yv[8]);

        run_scenario("hold5", 12, 16, -1, -1, 4'd0, 4'd0, 1'b0);
        check("hold5 done_cycle", done_cyc, 43);
        check("hold5 out_count", ov_cnt, 24);

        run_scenario("fsel", -1, -1, -1, 10, 4'd9, 4'd2, 1'b0);
        check("fsel done_count", done_cnt, 1);
        check("fsel done_cycle", done_cyc, 38);

        run_scenario("abort", -1, -1, 15, -1, 4'd5, 4'd5, 1'b0);
        check("abort done_count", done_cnt, 0);

        run_scenario("rerun", -1, -1, -1, -1, 4'd0, 4'd0, 1'b0);
        check("rerun xins@2", x_c2, 40'h0B_02_04_07_00);
        check("rerun done_cycle", done_cyc, 38);
        check("rerun out_count", ov_cnt, 24);

        run_scenario("starthold", 0, 3, -1, -1, 4'd3, 4'd3, 1'b0);
        check("starthold first_run", first_run, 5);
        check("starthold done_cycle", done_cyc, 41);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = W'($urandom);
        for (int t = 0; t < 2; t++) begin
            run_scenario($sformatf("rand%0d", t), -1, -1, -1, -1, 4'($urandom), 4'($urandom), 1'b1);
            check($sformatf("rand%0d out_count", t), ov_cnt, 24);
            check($sformatf("rand%0d done_count", t), done_cnt, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
